// File: rtl/dst_reg_select_stage.sv
// Registered N:1 write-back register selector for the ID/EX boundary; 1-cycle latency, no comb path.
// Stall holds all outputs, flush loads a bubble; there is no ready/credit return path.
module dst_reg_select_stage #(
    parameter int WIDTH         = 5,
    parameter int NUM_IN        = 3,
    parameter int SEL_W         = 2,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    input  logic                    regwrite_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    output logic                    regwrite_o,
    output logic                    sel_err_o
);

    logic [WIDTH-1:0] cand;
    logic             sel_ok;
    logic             wr_qual;

    // Only codes matching an existing candidate are legal; anything above is flagged.
    always_comb begin
        cand   = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                cand   = data_i[k*WIDTH +: WIDTH];
                sel_ok = 1'b1;
            end
        end
    end

    assign wr_qual = regwrite_i && !(ZERO_SUPPRESS && (cand == '0));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            regwrite_o <= 1'b0;
            sel_err_o  <= 1'b0;
        end else if (flush_i) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            regwrite_o <= 1'b0;
        end else if (!stall_i) begin
            if (!valid_i) begin
                data_o     <= '0;
                valid_o    <= 1'b0;
                regwrite_o <= 1'b0;
            end else if (sel_ok) begin
                data_o     <= cand;
                valid_o    <= 1'b1;
                regwrite_o <= wr_qual;
            end else begin
                data_o     <= '0;
                valid_o    <= 1'b1;
                regwrite_o <= 1'b0;
                sel_err_o  <= 1'b1;
            end
        end
    end

endmodule
